// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO: occupancy count, inclusive almost-full/almost-empty thresholds, overflow/underflow pulses.
// Registered read adds one cycle of latency; FWFT shows the head word. Full rejects writes and empty rejects reads.
module sync_fifo_cfg #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  output logic             overflow,
  output logic [DSIZE-1:0] rdata,
  input  logic             rinc,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic             underflow,
  output logic [ASIZE:0]   count
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_V  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_V = AEMPTY_TH[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic             wen, ren;

  // All status derives from the registered pointers only.
  assign count         = wptr - rptr;
  assign rempty        = (wptr == rptr);
  assign wfull         = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);
  assign walmost_full  = (count >= AFULL_V);
  assign ralmost_empty = (count <= AEMPTY_V);

  assign wen = winc && !wfull && !rst;
  assign ren = rinc && !rempty && !rst;

  always_ff @(posedge clk) begin
    if (wen) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen) wptr <= wptr + 1'b1;
      if (ren) rptr <= rptr + 1'b1;
      overflow  <= winc && wfull;
      underflow <= rinc && rempty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      // Holds the last popped word until the next accepted read.
      always_ff @(posedge clk) begin
        if (rst)      rdata_q <= '0;
        else if (ren) rdata_q <= mem[rptr[ASIZE-1:0]];
      end
      assign rdata = rdata_q;
    end
  endgenerate
endmodule

// File: doc/sync_fifo_cfg.md
Name: sync_fifo_cfg

Overview:
Single-clock, parametrised FIFO and the next generation of the team's dual-clock FIFO top. It is used where producer and consumer share one clock, so no pointer synchronisers or Gray coding are needed. Compared with the dual-clock FIFO it adds:
- occupancy count;
- programmable almost-full and almost-empty flags;
- overflow and underflow error pulses;
- a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; depth = 2**ASIZE entries.
- AFULL_TH, 14, walmost_full asserts when count >= AFULL_TH. Legal range 1..2**ASIZE.
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH. Legal range 0..2**ASIZE-1.
- FWFT, 0, read mode. 0 = registered read (data one cycle after rinc). 1 = head word presented on rdata whenever not empty.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- wdata, input, DSIZE, write data.
- winc, input, 1, write request.
- wfull, output, 1, FIFO holds 2**ASIZE entries.
- walmost_full, output, 1, count >= AFULL_TH.
- overflow, output, 1, one-cycle pulse: previous cycle's winc was rejected.
- rdata, output, DSIZE, read data.
- rinc, input, 1, read request (pop).
- rempty, output, 1, FIFO holds 0 entries.
- ralmost_empty, output, 1, count <= AEMPTY_TH.
- underflow, output, 1, one-cycle pulse: previous cycle's rinc was rejected.
- count, output, ASIZE+1, current occupancy, 0..2**ASIZE.

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high.
- Storage: 2**ASIZE x DSIZE register array, written on clk; no reset of array contents.
- Pointers: wptr and rptr are ASIZE+1-bit binary counters. The address is the low ASIZE bits; the MSB is the wrap bit. Both wrap naturally modulo 2**(ASIZE+1).
- count = wptr - rptr, modulo 2**(ASIZE+1).
- Status flags:
  - rempty = (wptr == rptr).
  - wfull = (low bits equal) and (MSBs differ).
  - All flags and count are functions of registered pointers only; no combinational path from winc/rinc to any flag.
- Write accept (wen) = winc and not wfull. On wen: mem[waddr] <= wdata, wptr increments.
- Read accept (ren) = rinc and not rempty. On ren: rptr increments.
- Simultaneous winc and rinc:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow pulses; no bypass.
  - Empty: write accepted, read rejected, underflow pulses; no bypass.
- overflow <= winc and wfull, registered, high for exactly one cycle per rejected write.
- underflow <= rinc and rempty, same rule for rejected reads.
- FWFT=0 read path:
  - rdata is a register loaded with mem[raddr] on ren.
  - Valid the cycle after the accepted rinc; holds its value otherwise, including when empty.
- FWFT=1 read path:
  - rdata = mem[raddr] when not rempty, else all zeros.
  - Word written at edge N is visible on rdata from edge N+1 if the FIFO was empty.
  - ren advances to the next word, visible after that edge.
- Reset (rst high at an edge):
  - wptr, rptr, count = 0; rempty = 1; wfull = 0; overflow = 0; underflow = 0.
  - rdata register = 0 (FWFT=0); rdata = 0 by the empty rule (FWFT=1).
  - walmost_full = 0 unless AFULL_TH is 0 (illegal). ralmost_empty = 1.
  - winc and rinc are ignored while rst is high.
  - Reset mid-operation discards all contents on that edge.
- Threshold boundaries are inclusive on both flags.
- When AFULL_TH = 2**ASIZE, walmost_full equals wfull.
- When AEMPTY_TH = 0, ralmost_empty equals rempty.

Test Plan:
- Fill: DSIZE=8, ASIZE=4, FWFT=0. Reset, then 16 writes 0x00..0x0F.
  -> count steps 1..16.
  -> walmost_full rises on the edge count becomes 14.
  -> wfull = 1 at 16; overflow stays 0.
- Overflow: full FIFO, one extra winc with wdata=0xAA.
  -> overflow high exactly one cycle; count stays 16.
  -> Subsequent drain returns 0x00..0x0F; 0xAA is never read.
- Drain and underflow: 16 reads.
  -> rdata 0x00..0x0F, each one cycle after its rinc.
  -> ralmost_empty rises when count reaches 2; rempty at 0.
  -> One extra rinc gives a one-cycle underflow pulse; rdata holds 0x0F.
- Simultaneous access: with count=5, assert winc and rinc together for 20 cycles.
  -> count stays 5; data order preserved across pointer wrap; no error pulses.
  -> With the FIFO full and both asserted for one cycle: count goes to 15, overflow pulses once.
- FWFT=1 mode: reset, then write 0x3C.
  -> rdata = 0x3C on the next cycle with no rinc.
  -> After a single rinc: rempty = 1 and rdata = 0x00.
  -> Empty FIFO with winc and rinc together: count goes to 1, underflow pulses.
- Reset mid-run: assert rst with count=9 while winc is also high.
  -> Next cycle: count = 0, rempty = 1, wfull = 0, rdata = 0.
  -> Neither an error pulse nor a write from that cycle appears.
